ddr3_dqs_dly_track: RTL and testbench

//  Read-DQS delay-tracking controller for one DDR3 lane. Consumes the eye-monitor EARLY/LATE flags
//  and drives the DELAY_LINE_MOVE/DIRECTION/LOAD controls of the lane's DQS IOD.

---
 rtl/ddr3_phy_pkg.sv | 18 +
 rtl/ddr3_eye_vote_cnt.sv | 53 +++++
 rtl/ddr3_dqs_dly_track.sv | 162 ++++++++++++++++
 tb/tb_ddr3_dqs_dly_track.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ddr3_phy_pkg.sv
// Shared DDR3 PHY lane definitions: DQS tracking FSM states and delay-line direction codes.
package ddr3_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_MOVE,
    ST_HALT
  } dqs_trk_state_t;

  localparam logic DLY_INC = 1'b1;
  localparam logic DLY_DEC = 1'b0;

endpackage

// File: rtl/ddr3_eye_vote_cnt.sv
// Eye-monitor vote window: counts EARLY-only and LATE-only samples over VOTE_N cycles
// and reports whether either side leads the other by at least VOTE_THR.
module ddr3_eye_vote_cnt
  import ddr3_phy_pkg::*;
#(
  parameter int VOTE_N   = 16,
  parameter int VOTE_THR = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic early,
  input  logic late,
  output logic vote_up,
  output logic vote_dn,
  output logic vote_done
);

  localparam int CNT_W = $clog2(VOTE_N + 1);

  logic [CNT_W-1:0] early_cnt;
  logic [CNT_W-1:0] late_cnt;
  logic [CNT_W-1:0] smp_cnt;
  logic [CNT_W:0]   early_x;
  logic [CNT_W:0]   late_x;
  logic [CNT_W:0]   thr_x;

  // Window counters; a sample with both or neither flag set is a non-vote.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      early_cnt <= '0;
      late_cnt  <= '0;
      smp_cnt   <= '0;
    end else if (en) begin
      smp_cnt <= smp_cnt + CNT_W'(1);
      if (early && !late)
        early_cnt <= early_cnt + CNT_W'(1);
      else if (late && !early)
        late_cnt <= late_cnt + CNT_W'(1);
    end
  end

  // Margin compare one bit wider than the counters so the threshold add cannot wrap.
  assign early_x   = {1'b0, early_cnt};
  assign late_x    = {1'b0, late_cnt};
  assign thr_x     = (CNT_W + 1)'(VOTE_THR);
  assign vote_up   = early_x >= (late_x + thr_x);
  assign vote_dn   = late_x >= (early_x + thr_x);
  // High during the last sample cycle so the FSM reaches DECIDE with the full window counted.
  assign vote_done = en && (smp_cnt == CNT_W'(VOTE_N - 1));

endmodule

// File: rtl/ddr3_dqs_dly_track.sv
// Read-DQS delay tracking for one DDR3 lane: votes eye-monitor flags over a window and
// steps the IOD RX delay line one tap per decision, tracking the tap estimate locally.
module ddr3_dqs_dly_track
  import ddr3_phy_pkg::*;
#(
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 127,
  parameter int INIT_TAP   = 1,
  parameter int VOTE_N     = 16,
  parameter int VOTE_THR   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_N     = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             TRACK_EN,
  input  logic             LOAD_REQ,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  output logic [TAP_W-1:0] TAP_COUNT,
  output logic             LOCKED,
  output logic             AT_LIMIT,
  output logic             ERROR
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int LCK_W = $clog2(LOCK_N + 1);

  dqs_trk_state_t   state;
  logic [SET_W-1:0] settle_cnt;
  logic [LCK_W-1:0] lock_cnt;
  logic [LCK_W-1:0] lock_nxt;
  logic             vote_up;
  logic             vote_dn;
  logic             vote_done;
  logic             go_up;
  logic             go_dn;

  ddr3_eye_vote_cnt #(
    .VOTE_N   (VOTE_N),
    .VOTE_THR (VOTE_THR)
  ) u_vote (
    .clk       (FAB_CLK),
    .rst_n     (RESET_N),
    .clr       (state == ST_CLEAR),
    .en        (state == ST_SAMPLE),
    .early     (EYE_MONITOR_EARLY),
    .late      (EYE_MONITOR_LATE),
    .vote_up   (vote_up),
    .vote_dn   (vote_dn),
    .vote_done (vote_done)
  );

  // A vote toward an end stop is suppressed rather than stepping past the legal range.
  assign go_up    = vote_up && (TAP_COUNT != TAP_W'(MAX_TAP));
  assign go_dn    = vote_dn && (TAP_COUNT != '0);
  assign lock_nxt = (lock_cnt == LCK_W'(LOCK_N)) ? lock_cnt : lock_cnt + LCK_W'(1);

  // Tracking FSM; every IOD control is a registered output. DIRECTION is set leaving
  // DECIDE and the MOVE pulse follows one cycle later, so direction always leads the move.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state                   <= ST_IDLE;
      settle_cnt              <= '0;
      lock_cnt                <= '0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      DELAY_LINE_LOAD         <= 1'b0;
      TAP_COUNT               <= TAP_W'(INIT_TAP);
      LOCKED                  <= 1'b0;
      AT_LIMIT                <= 1'b0;
      ERROR                   <= 1'b0;
    end else begin
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_LOAD         <= 1'b0;
      if (LOAD_REQ) begin
        state           <= ST_LOAD;
        DELAY_LINE_LOAD <= 1'b1;
        TAP_COUNT       <= TAP_W'(INIT_TAP);
        LOCKED          <= 1'b0;
        AT_LIMIT        <= 1'b0;
        ERROR           <= 1'b0;
        lock_cnt        <= '0;
      end else if (DELAY_LINE_OUT_OF_RANGE && (state != ST_LOAD)) begin
        ERROR <= 1'b1;
        state <= ST_HALT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (TRACK_EN && !ERROR) begin
              state                   <= ST_CLEAR;
              EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
            end
          end
          ST_LOAD: state <= ST_IDLE;
          ST_CLEAR: begin
            if (!TRACK_EN) begin
              state <= ST_IDLE;
            end else begin
              state      <= ST_SETTLE;
              settle_cnt <= '0;
            end
          end
          ST_SETTLE: begin
            if (!TRACK_EN)
              state <= ST_IDLE;
            else if (settle_cnt == SET_W'(SETTLE_CYC - 1))
              state <= ST_SAMPLE;
            else
              settle_cnt <= settle_cnt + SET_W'(1);
          end
          ST_SAMPLE: begin
            if (!TRACK_EN)
              state <= ST_IDLE;
            else if (vote_done)
              state <= ST_DECIDE;
          end
          ST_DECIDE: begin
            if (go_up || go_dn) begin
              DELAY_LINE_DIRECTION <= go_up ? DLY_INC : DLY_DEC;
              state                <= ST_MOVE;
            end else begin
              if (vote_up || vote_dn)
                AT_LIMIT <= 1'b1;
              lock_cnt <= lock_nxt;
              LOCKED   <= (lock_nxt == LCK_W'(LOCK_N));
              if (TRACK_EN) begin
                state                   <= ST_CLEAR;
                EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_MOVE: begin
            DELAY_LINE_MOVE <= 1'b1;
            TAP_COUNT       <= (DELAY_LINE_DIRECTION == DLY_INC) ? TAP_COUNT + TAP_W'(1)
                                                                 : TAP_COUNT - TAP_W'(1);
            lock_cnt        <= '0;
            LOCKED          <= 1'b0;
            if (TRACK_EN) begin
              state                   <= ST_CLEAR;
              EYE_MONITOR_CLEAR_FLAGS <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_HALT: state <= ST_HALT;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_dqs_dly_track.sv
// Directed bench for ddr3_dqs_dly_track: a vector table for reset/load/error priority,
// plus hand-sequenced tracking loops for stepping, locking, limits, halt and enable drop.
module tb_ddr3_dqs_dly_track;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       track_en = 1'b0;
  logic       load_req = 1'b0;
  logic       early_set = 1'b0;
  logic       late_set = 1'b0;
  logic       oor = 1'b0;
  logic       alt_mode = 1'b0;
  logic       alt_ph = 1'b0;
  logic       eye_e;
  logic       eye_l;
  logic       clr_o;
  logic       mv_o;
  logic       dir_o;
  logic       ld_o;
  logic [7:0] tap_o;
  logic       lock_o;
  logic       atl_o;
  logic       err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Alternating pattern gives an exact 8/8 split over any 16 consecutive samples.
  always @(negedge clk) alt_ph <= ~alt_ph;
  assign eye_e = alt_mode ? alt_ph  : early_set;
  assign eye_l = alt_mode ? ~alt_ph : late_set;

  ddr3_dqs_dly_track dut (
    .FAB_CLK                 (clk),
    .RESET_N                 (rst_n),
    .TRACK_EN                (track_en),
    .LOAD_REQ                (load_req),
    .EYE_MONITOR_EARLY       (eye_e),
    .EYE_MONITOR_LATE        (eye_l),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .EYE_MONITOR_CLEAR_FLAGS (clr_o),
    .DELAY_LINE_MOVE         (mv_o),
    .DELAY_LINE_DIRECTION    (dir_o),
    .DELAY_LINE_LOAD         (ld_o),
    .TAP_COUNT               (tap_o),
    .LOCKED                  (lock_o),
    .AT_LIMIT                (atl_o),
    .ERROR                   (err_o)
  );

  typedef struct {
    logic       rst_n, trk, ld, e, l, oor;
    logic       clr, mv, lod, lock, atl, err;
    logic [7:0] tap;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet(input int n, input string name);
    int spur = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (clr_o || mv_o || ld_o) spur++;
    end
    chk(name, 32'(spur), 32'd0);
  endtask

  // Called at the cycle CLEAR_FLAGS is high; returns at the next CLEAR_FLAGS cycle.
  task automatic one_loop(input bit mv, input bit dir, input int tap, input bit lck, input bit atl);
    int spur = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (clr_o || mv_o) spur++;
    end
    chk("loop_quiet", 32'(spur), 32'd0);
    step();
    if (mv) begin
      chk("dir_lead", 32'({dir_o, mv_o, lock_o}), 32'({dir, 1'b0, lck}));
      step();
      chk("move_pulse", 32'({mv_o, clr_o, dir_o, lock_o, atl_o}), 32'({1'b1, 1'b1, dir, 1'b0, atl}));
      chk("tap_after_move", 32'(tap_o), 32'(tap));
    end else begin
      chk("no_move", 32'({mv_o, clr_o, lock_o, atl_o}), 32'({1'b0, 1'b1, lck, atl}));
      chk("tap_hold", 32'(tap_o), 32'(tap));
    end
  endtask

  initial begin
    //          rst trk ld  e   l   oor   clr mv  ld  lck atl err  tap
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'd1};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'd1};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'd1};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'd1};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'd1};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'd1};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 8'd1};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'd1};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 8'd1};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 8'd1};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 8'd1};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'd1};

    // Reset, idle flag rejection, load and error priority
    for (int v = 0; v < 12; v++) begin
      rst_n = tbl[v].rst_n; track_en = tbl[v].trk; load_req = tbl[v].ld;
      early_set = tbl[v].e; late_set = tbl[v].l; oor = tbl[v].oor;
      step();
      chk($sformatf("vec%0d", v),
          32'({clr_o, mv_o, ld_o, lock_o, atl_o, err_o, tap_o}),
          32'({tbl[v].clr, tbl[v].mv, tbl[v].lod, tbl[v].lock, tbl[v].atl, tbl[v].err, tbl[v].tap}));
    end

    // Constant EARLY: two up-steps with a 27-cycle loop
    early_set = 1'b1; late_set = 1'b0; track_en = 1'b1;
    step();
    chk("first_clear", 32'({clr_o, tap_o}), 32'({1'b1, 8'd1}));
    one_loop(1'b1, 1'b1, 2, 1'b0, 1'b0);
    one_loop(1'b1, 1'b1, 3, 1'b0, 1'b0);

    // Balanced votes lock after four decisions, then a LATE majority steps down
    alt_mode = 1'b1;
    for (int k = 0; k < 4; k++) one_loop(1'b0, 1'b0, 3, (k == 3), 1'b0);
    alt_mode = 1'b0; early_set = 1'b0; late_set = 1'b1;
    one_loop(1'b1, 1'b0, 2, 1'b1, 1'b0);

    // Walk down to tap 0 and hit the lower limit
    one_loop(1'b1, 1'b0, 1, 1'b0, 1'b0);
    one_loop(1'b1, 1'b0, 0, 1'b0, 1'b0);
    one_loop(1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Reload, then walk up to MAX_TAP and hit the upper limit
    load_req = 1'b1; track_en = 1'b0;
    step();
    chk("load_pulse", 32'({ld_o, mv_o, atl_o, tap_o}), 32'({1'b1, 1'b0, 1'b0, 8'd1}));
    load_req = 1'b0;
    step();
    chk("load_single", 32'({ld_o, clr_o}), 32'd0);
    early_set = 1'b1; late_set = 1'b0; track_en = 1'b1;
    step();
    chk("restart_clear", 32'(clr_o), 32'd1);
    for (int t = 2; t <= 127; t++) one_loop(1'b1, 1'b1, t, 1'b0, 1'b0);
    one_loop(1'b0, 1'b1, 127, 1'b0, 1'b1);

    // OUT_OF_RANGE mid-sample halts until LOAD_REQ
    for (int i = 0; i < 12; i++) step();
    oor = 1'b1;
    step();
    chk("oor_halt", 32'({err_o, mv_o, clr_o, ld_o}), 32'({1'b1, 1'b0, 1'b0, 1'b0}));
    oor = 1'b0;
    quiet(40, "halt_quiet");
    chk("halt_err_sticky", 32'({err_o, tap_o}), 32'({1'b1, 8'd127}));
    load_req = 1'b1;
    step();
    chk("halt_load", 32'({ld_o, err_o, atl_o, tap_o}), 32'({1'b1, 1'b0, 1'b0, 8'd1}));
    load_req = 1'b0; track_en = 1'b0;
    step();
    chk("halt_to_idle", 32'({ld_o, clr_o, err_o}), 32'd0);

    // TRACK_EN dropped mid-sample abandons the window
    track_en = 1'b1;
    step();
    chk("en_clear", 32'(clr_o), 32'd1);
    for (int i = 0; i < 14; i++) step();
    track_en = 1'b0;
    quiet(40, "drop_sample_quiet");
    chk("drop_sample_tap", 32'(tap_o), 32'd1);

    // TRACK_EN dropped in DECIDE still completes the pending move
    track_en = 1'b1;
    step();
    chk("en_clear2", 32'(clr_o), 32'd1);
    for (int i = 0; i < 25; i++) step();
    track_en = 1'b0;
    step();
    chk("decide_drop_dir", 32'({dir_o, mv_o}), 32'({1'b1, 1'b0}));
    step();
    chk("decide_drop_move", 32'({mv_o, clr_o, tap_o}), 32'({1'b1, 1'b0, 8'd2}));
    quiet(30, "decide_drop_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
